vlsu_cmt_tracker: RTL and testbench
===================================

Name: vlsu_cmt_tracker

Overview:
- Commit/completion tracker downstream of the VLSU AXI master port.
- Records each vector memory request dispatched to the VLSU control machine, and counts the AXI transactions issued for it (AR or AW handshakes).
- Retires a request once all its transactions have completed: final R beat for loads, B response for stores.
- Returns in-order responses (reqId plus error flag) to the issuing processing element.

Parameters:
- NrReqs, 4, maximum in-flight requests (queue depth, power of 2, ≥2)
- IdWidth, 3, width of reqId
- CntWidth, 8, width of the per-request outstanding-transaction counter

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  new request dispatched
- req_ready_o  out  1  queue has a free entry
- req_id_i  in  IdWidth  reqId of new request
- req_is_load_i  in  1  1 = load, 0 = store
- txn_valid_i  in  1  one AR/AW handshake occurred for the current issuing request
- txn_ready_o  out  1  an open issuing entry exists and its counter is not saturated
- txn_last_i  in  1  qualifies txn_valid_i; this is the last transaction of the issuing request
- ld_cmpl_i  in  1  pulse: R beat with rlast handshaked
- st_cmpl_i  in  1  pulse: B handshaked
- cmpl_err_i  in  1  qualifies either completion; rresp/bresp was SLVERR/DECERR
- resp_valid_o  out  1  head request retired
- resp_ready_i  in  1  consumer accepts response
- resp_id_o  out  IdWidth  reqId of head
- resp_err_o  out  1  sticky error of head
- spurious_o  out  1  one-cycle pulse: completion with no matching entry

Behaviour:
- Storage: circular queue of NrReqs entries. Each entry holds:
  - id, is_load
  - closed (last transaction issued)
  - out_cnt (CntWidth bits, issued minus completed)
  - err (sticky)
- Pointers, each log2(NrReqs) bits with a wrap bit: head (retire), iss (issuing), tail (alloc).
- Reset (rst_i high at an edge):
  - all pointers 0, all entries invalid, spurious_o register 0.
  - Following the reset edge: req_ready_o=1, txn_ready_o=0, resp_valid_o=0, resp_id_o=0, resp_err_o=0, spurious_o=0.
  - Reset mid-operation discards all in-flight state; no responses are produced for discarded requests.
- Allocate:
  - Happens when req_valid_i && req_ready_o.
  - Writes entry[tail] with id, is_load, closed=0, out_cnt=0, err=0; tail++.
  - req_ready_o = !full; full when tail and head differ only in the wrap bit.
- Issue:
  - txn_ready_o = (iss != tail) && out_cnt[iss] != all-ones. It is derived from registered state only, so an entry allocated in cycle N is issuable from cycle N+1.
  - On txn_valid_i && txn_ready_o: out_cnt[iss]++. If txn_last_i, also set closed[iss] and iss++.
  - txn_valid_i while txn_ready_o=0 is ignored (upstream contract violation; an assertion flags it).
- Completion:
  - ld_cmpl_i targets the oldest entry in [head, iss] with is_load=1 and out_cnt>0, searched from head. st_cmpl_i does the same with is_load=0.
  - On a target: out_cnt-- and err |= cmpl_err_i.
  - No target: no state change; spurious_o=1 next cycle.
  - ld_cmpl_i and st_cmpl_i in the same cycle are both applied (they target distinct entries).
  - An issue and a completion on the same entry in the same cycle give a net out_cnt change of 0.
- Retire:
  - resp_valid_o is registered. It is 1 when head != iss and entry[head] has closed=1 and out_cnt=0. resp_id_o and resp_err_o come from entry[head].
  - This gives one cycle from the final completion edge to resp_valid_o.
  - On resp_valid_o && resp_ready_i: head++, entry invalidated. The next head may be presented the following cycle.
  - resp_valid_o, once high, stays high with stable data until accepted.
- Throughput: one allocate, one issue, one load completion, one store completion and one retire may all happen in the same cycle.
- Full with a simultaneous retire: req_ready_o stays 0 that cycle (computed from registered pointers); the freed slot is usable next cycle.
- Pointer wrap: indices wrap modulo NrReqs; the wrap bit distinguishes full from empty.

Test Plan:
1. Reset, then idle → req_ready_o=1, txn_ready_o=0, resp_valid_o=0 for 10 cycles.
2. Store id 5: 3 txns (last on 3rd), then 3 st_cmpl_i → resp_valid_o the cycle after the 3rd completion, resp_id_o=5, resp_err_o=0. Hold resp_ready_i=0 for 4 cycles → data stable.
3. Load id 1, then store id 2. Interleave: 2 load txns and 1 store txn, then st_cmpl before both ld_cmpl → id 2 entry drained but not presented until id 1 retires; order out is 1 then 2.
4. Fill 4 requests → req_ready_o=0. Retire one → req_ready_o=1 the next cycle. Run 10 requests total to exercise pointer wrap; all ids are returned in order.
5. ld_cmpl_i with no open load entry → spurious_o pulses once, no other state change. Completion with cmpl_err_i=1 on the 2nd of 3 txns → resp_err_o=1.
6. rst_i asserted with 3 entries in flight → next cycle resp_valid_o=0 and req_ready_o=1. Later completions produce spurious_o only.

Source files
------------

// File: rtl/vlsu_cmt_tracker_if.sv
// Bundle of the request, issue, completion and response signals of the VLSU commit tracker.
// Valid/ready: a transfer happens on a rising edge where both are high; valid never waits on ready.
interface vlsu_cmt_tracker_if #(
  parameter int unsigned IdWidth = 3
);
  logic               req_valid_i;
  logic               req_ready_o;
  logic [IdWidth-1:0] req_id_i;
  logic               req_is_load_i;
  logic               txn_valid_i;
  logic               txn_ready_o;
  logic               txn_last_i;
  logic               ld_cmpl_i;
  logic               st_cmpl_i;
  logic               cmpl_err_i;
  logic               resp_valid_o;
  logic               resp_ready_i;
  logic [IdWidth-1:0] resp_id_o;
  logic               resp_err_o;
  logic               spurious_o;

  modport master (
    output req_valid_i, req_id_i, req_is_load_i, txn_valid_i, txn_last_i,
           ld_cmpl_i, st_cmpl_i, cmpl_err_i, resp_ready_i,
    input  req_ready_o, txn_ready_o, resp_valid_o, resp_id_o, resp_err_o, spurious_o
  );

  modport slave (
    input  req_valid_i, req_id_i, req_is_load_i, txn_valid_i, txn_last_i,
           ld_cmpl_i, st_cmpl_i, cmpl_err_i, resp_ready_i,
    output req_ready_o, txn_ready_o, resp_valid_o, resp_id_o, resp_err_o, spurious_o
  );
endinterface

// File: rtl/vlsu_cmt_tracker.sv
// In-order commit tracker: counts AXI transactions per vector request and retires each
// request once all its transactions have completed.
module vlsu_cmt_tracker #(
  parameter int unsigned NrReqs   = 4,
  parameter int unsigned IdWidth  = 3,
  parameter int unsigned CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  vlsu_cmt_tracker_if.slave   bus
);

  localparam int unsigned PtrW = $clog2(NrReqs);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

  typedef logic [PtrW:0]   ptr_t;
  typedef logic [PtrW-1:0] idx_t;

  typedef struct packed {
    logic                valid;
    logic [IdWidth-1:0]  id;
    logic                is_load;
    logic                closed;
    logic [CntWidth-1:0] cnt;
    logic                err;
  } entry_t;

  entry_t ent_q [NrReqs];
  entry_t ent_d [NrReqs];

  ptr_t head_q, head_d, iss_q, iss_d, tail_q, tail_d;

  logic               resp_valid_q, resp_valid_d;
  logic [IdWidth-1:0] resp_id_q, resp_id_d;
  logic               resp_err_q, resp_err_d;
  logic               spurious_q, spurious_d;

  logic full, do_alloc, do_issue, do_retire;
  idx_t head_idx, iss_idx, tail_idx, hd_next, scan_idx;
  logic ld_hit, st_hit;
  idx_t ld_idx, st_idx;

  assign head_idx = head_q[PtrW-1:0];
  assign iss_idx  = iss_q[PtrW-1:0];
  assign tail_idx = tail_q[PtrW-1:0];

  assign full = (head_q[PtrW] != tail_q[PtrW]) && (head_idx == tail_idx);

  assign bus.req_ready_o  = !full;
  assign bus.txn_ready_o  = (iss_q != tail_q) && (ent_q[iss_idx].cnt != '1);
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_id_o    = resp_id_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.spurious_o   = spurious_q;

  assign do_alloc  = bus.req_valid_i && !full;
  assign do_issue  = bus.txn_valid_i && bus.txn_ready_o;
  assign do_retire = resp_valid_q && bus.resp_ready_i;

  // Oldest-first search from head; only issued entries can have a non-zero count.
  always_comb begin
    ld_hit   = 1'b0;
    st_hit   = 1'b0;
    ld_idx   = '0;
    st_idx   = '0;
    scan_idx = '0;
    for (int i = 0; i < NrReqs; i++) begin
      scan_idx = head_idx + idx_t'(i);
      if (!ld_hit && ent_q[scan_idx].valid && ent_q[scan_idx].is_load &&
          (ent_q[scan_idx].cnt != '0)) begin
        ld_hit = 1'b1;
        ld_idx = scan_idx;
      end
      if (!st_hit && ent_q[scan_idx].valid && !ent_q[scan_idx].is_load &&
          (ent_q[scan_idx].cnt != '0)) begin
        st_hit = 1'b1;
        st_idx = scan_idx;
      end
    end
  end

  always_comb begin
    ent_d  = ent_q;
    head_d = head_q;
    iss_d  = iss_q;
    tail_d = tail_q;

    if (do_alloc) begin
      ent_d[tail_idx].valid   = 1'b1;
      ent_d[tail_idx].id      = bus.req_id_i;
      ent_d[tail_idx].is_load = bus.req_is_load_i;
      ent_d[tail_idx].closed  = 1'b0;
      ent_d[tail_idx].cnt     = '0;
      ent_d[tail_idx].err     = 1'b0;
      tail_d                  = tail_q + ptr_t'(1);
    end

    // Issue and completion may hit the same slot; applying both nets to zero.
    for (int s = 0; s < NrReqs; s++) begin
      if (do_issue && (iss_idx == idx_t'(s)))
        ent_d[s].cnt = ent_d[s].cnt + CntOne;
      if (bus.ld_cmpl_i && ld_hit && (ld_idx == idx_t'(s))) begin
        ent_d[s].cnt = ent_d[s].cnt - CntOne;
        ent_d[s].err = ent_d[s].err | bus.cmpl_err_i;
      end
      if (bus.st_cmpl_i && st_hit && (st_idx == idx_t'(s))) begin
        ent_d[s].cnt = ent_d[s].cnt - CntOne;
        ent_d[s].err = ent_d[s].err | bus.cmpl_err_i;
      end
    end

    if (do_issue && bus.txn_last_i) begin
      ent_d[iss_idx].closed = 1'b1;
      iss_d                 = iss_q + ptr_t'(1);
    end

    if (do_retire) begin
      ent_d[head_idx].valid  = 1'b0;
      ent_d[head_idx].closed = 1'b0;
      head_d                 = head_q + ptr_t'(1);
    end

    // Response is registered from the post-update state of the (possibly new) head.
    hd_next      = head_d[PtrW-1:0];
    resp_valid_d = (head_d != iss_d) && ent_d[hd_next].closed && (ent_d[hd_next].cnt == '0);
    resp_id_d    = ent_d[hd_next].id;
    resp_err_d   = ent_d[hd_next].err;
    spurious_d   = (bus.ld_cmpl_i && !ld_hit) || (bus.st_cmpl_i && !st_hit);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q       <= '0;
      iss_q        <= '0;
      tail_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
      spurious_q   <= 1'b0;
      for (int s = 0; s < NrReqs; s++) ent_q[s] <= '0;
    end else begin
      head_q       <= head_d;
      iss_q        <= iss_d;
      tail_q       <= tail_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
      spurious_q   <= spurious_d;
      for (int s = 0; s < NrReqs; s++) ent_q[s] <= ent_d[s];
    end
  end

  // Upstream must only report a transaction while one can be accepted.
  txn_contract_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.txn_valid_i && !bus.txn_ready_o));

endmodule

// File: tb/tb_vlsu_cmt_tracker.sv
// Directed testbench for vlsu_cmt_tracker: allocation, issue, completion, retire order,
// full/wrap, spurious completions, error stickiness and mid-flight reset.
module tb_vlsu_cmt_tracker;

  logic clk_i;
  logic rst_i;
  int   checks;
  int   errors;
  logic [2:0] exp_q[$];

  vlsu_cmt_tracker_if #(.IdWidth(3)) bus ();

  vlsu_cmt_tracker #(.NrReqs(4), .IdWidth(3), .CntWidth(8)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // driver tasks: inputs change 1 time unit after the rising edge, outputs sampled there too
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i   = 1'b0;
    bus.req_id_i      = '0;
    bus.req_is_load_i = 1'b0;
    bus.txn_valid_i   = 1'b0;
    bus.txn_last_i    = 1'b0;
    bus.ld_cmpl_i     = 1'b0;
    bus.st_cmpl_i     = 1'b0;
    bus.cmpl_err_i    = 1'b0;
    bus.resp_ready_i  = 1'b0;
  endtask

  task automatic do_alloc(input logic [2:0] id, input logic is_load);
    bus.req_valid_i   = 1'b1;
    bus.req_id_i      = id;
    bus.req_is_load_i = is_load;
    tick();
    bus.req_valid_i   = 1'b0;
  endtask

  task automatic do_txn(input logic last);
    bus.txn_valid_i = 1'b1;
    bus.txn_last_i  = last;
    tick();
    bus.txn_valid_i = 1'b0;
    bus.txn_last_i  = 1'b0;
  endtask

  task automatic do_cmpl(input logic ld, input logic st, input logic err);
    bus.ld_cmpl_i  = ld;
    bus.st_cmpl_i  = st;
    bus.cmpl_err_i = err;
    tick();
    bus.ld_cmpl_i  = 1'b0;
    bus.st_cmpl_i  = 1'b0;
    bus.cmpl_err_i = 1'b0;
  endtask

  task automatic accept_resp(output logic [2:0] id, output logic err, output bit ok);
    ok  = 1'b0;
    id  = '0;
    err = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (bus.resp_valid_o === 1'b1) ok = 1'b1;
      else tick();
    end
    if (ok) begin
      id  = bus.resp_id_o;
      err = bus.resp_err_o;
      bus.resp_ready_i = 1'b1;
      tick();
      bus.resp_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    checks++;
    if ({bus.resp_id_o, bus.resp_err_o, bus.spurious_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_resp_fields got id=%0d err=%0b spur=%0b want 0/0/0",
               bus.resp_id_o, bus.resp_err_o, bus.spurious_o);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.req_ready_o, bus.txn_ready_o, bus.resp_valid_o} !== 3'b100) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got rr/tr/rv=%b want 100", i,
                 {bus.req_ready_o, bus.txn_ready_o, bus.resp_valid_o});
      end
      tick();
    end
  endtask

  task automatic test_store_single();
    do_alloc(3'd5, 1'b0);
    checks++;
    if (bus.txn_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL store_txn_ready got %0b want 1", bus.txn_ready_o);
    end
    do_txn(1'b0);
    do_txn(1'b0);
    do_txn(1'b1);
    checks++;
    if ({bus.txn_ready_o, bus.resp_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL store_closed got tr/rv=%b want 00", {bus.txn_ready_o, bus.resp_valid_o});
    end
    do_cmpl(1'b0, 1'b1, 1'b0);
    do_cmpl(1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL store_early_resp got %0b want 0", bus.resp_valid_o);
    end
    do_cmpl(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({bus.resp_valid_o, bus.resp_id_o, bus.resp_err_o, bus.spurious_o} !== 6'b1_101_0_0) begin
        errors++;
        $display("FAIL store_resp_hold cyc %0d got v=%0b id=%0d e=%0b sp=%0b want 1/5/0/0", i,
                 bus.resp_valid_o, bus.resp_id_o, bus.resp_err_o, bus.spurious_o);
      end
      tick();
    end
    bus.resp_ready_i = 1'b1;
    tick();
    bus.resp_ready_i = 1'b0;
    checks++;
    if (bus.resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL store_after_accept got %0b want 0", bus.resp_valid_o);
    end
  endtask

  task automatic test_order();
    logic [2:0] id;
    logic       err;
    bit         ok;
    do_alloc(3'd1, 1'b1);
    do_alloc(3'd2, 1'b0);
    do_txn(1'b0);
    do_txn(1'b1);
    do_txn(1'b1);
    do_cmpl(1'b0, 1'b1, 1'b0);
    checks++;
    if ({bus.resp_valid_o, bus.spurious_o} !== 2'b00) begin
      errors++;
      $display("FAIL order_store_blocked got rv/sp=%b want 00", {bus.resp_valid_o, bus.spurious_o});
    end
    do_cmpl(1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL order_load_partial got %0b want 0", bus.resp_valid_o);
    end
    do_cmpl(1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.resp_valid_o, bus.resp_id_o} !== 4'b1_001) begin
      errors++;
      $display("FAIL order_first got v=%0b id=%0d want 1/1", bus.resp_valid_o, bus.resp_id_o);
    end
    accept_resp(id, err, ok);
    checks++;
    if ({bus.resp_valid_o, bus.resp_id_o, bus.resp_err_o} !== 5'b1_010_0) begin
      errors++;
      $display("FAIL order_second got v=%0b id=%0d e=%0b want 1/2/0",
               bus.resp_valid_o, bus.resp_id_o, bus.resp_err_o);
    end
    accept_resp(id, err, ok);
    checks++;
    if (!ok || id !== 3'd2 || bus.resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL order_drain got ok=%0b id=%0d v=%0b want 1/2/0", ok, id, bus.resp_valid_o);
    end
  endtask

  task automatic test_full_wrap();
    logic [2:0] id;
    logic [2:0] exp_id;
    logic       err;
    bit         ok;
    for (int k = 0; k < 4; k++) begin
      do_alloc(3'(k), 1'b0);
      exp_q.push_back(3'(k));
    end
    checks++;
    if (bus.req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_req_ready got %0b want 0", bus.req_ready_o);
    end
    for (int r = 0; r < 10; r++) begin
      do_txn(1'b1);
      do_cmpl(1'b0, 1'b1, 1'b0);
      if (r == 0) begin
        checks++;
        if ({bus.req_ready_o, bus.resp_valid_o} !== 2'b01) begin
          errors++;
          $display("FAIL full_before_retire got rr/rv=%b want 01", {bus.req_ready_o, bus.resp_valid_o});
        end
      end
      accept_resp(id, err, ok);
      exp_id = exp_q.pop_front();
      checks++;
      if (!ok || id !== exp_id || err !== 1'b0) begin
        errors++;
        $display("FAIL wrap_order r=%0d got ok=%0b id=%0d e=%0b want 1/%0d/0", r, ok, id, err, exp_id);
      end
      if (r == 0) begin
        checks++;
        if (bus.req_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL full_after_retire got %0b want 1", bus.req_ready_o);
        end
      end
      if (r + 4 < 10) begin
        do_alloc(3'((r + 4) % 8), 1'b0);
        exp_q.push_back(3'((r + 4) % 8));
      end
    end
    checks++;
    if ({bus.req_ready_o, bus.txn_ready_o, bus.resp_valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL wrap_drained got rr/tr/rv=%b want 100",
               {bus.req_ready_o, bus.txn_ready_o, bus.resp_valid_o});
    end
  endtask

  task automatic test_spurious_err();
    logic [2:0] id;
    logic       err;
    bit         ok;
    do_alloc(3'd3, 1'b0);
    do_txn(1'b0);
    do_cmpl(1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.spurious_o, bus.txn_ready_o, bus.resp_valid_o} !== 3'b110) begin
      errors++;
      $display("FAIL spur_pulse got sp/tr/rv=%b want 110",
               {bus.spurious_o, bus.txn_ready_o, bus.resp_valid_o});
    end
    tick();
    checks++;
    if (bus.spurious_o !== 1'b0) begin
      errors++;
      $display("FAIL spur_once got %0b want 0", bus.spurious_o);
    end
    do_txn(1'b0);
    do_txn(1'b1);
    do_cmpl(1'b0, 1'b1, 1'b0);
    do_cmpl(1'b0, 1'b1, 1'b1);
    checks++;
    if ({bus.spurious_o, bus.resp_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL err_midway got sp/rv=%b want 00", {bus.spurious_o, bus.resp_valid_o});
    end
    do_cmpl(1'b0, 1'b1, 1'b0);
    accept_resp(id, err, ok);
    checks++;
    if (!ok || id !== 3'd3 || err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got ok=%0b id=%0d e=%0b want 1/3/1", ok, id, err);
    end
  endtask

  task automatic test_mid_reset();
    do_alloc(3'd4, 1'b1);
    do_alloc(3'd5, 1'b1);
    do_alloc(3'd6, 1'b1);
    do_txn(1'b1);
    do_txn(1'b0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if ({bus.resp_valid_o, bus.req_ready_o, bus.txn_ready_o} !== 3'b010) begin
      errors++;
      $display("FAIL mid_reset got rv/rr/tr=%b want 010",
               {bus.resp_valid_o, bus.req_ready_o, bus.txn_ready_o});
    end
    do_cmpl(1'b1, 1'b0, 1'b0);
    checks++;
    if ({bus.spurious_o, bus.resp_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL mid_reset_cmpl got sp/rv=%b want 10", {bus.spurious_o, bus.resp_valid_o});
    end
    do_cmpl(1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if ({bus.spurious_o, bus.resp_valid_o} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_quiet got sp/rv=%b want 00", {bus.spurious_o, bus.resp_valid_o});
    end
  endtask

  // final report
  initial begin
    checks = 0;
    errors = 0;
    rst_i  = 1'b1;
    idle_inputs();
    test_reset();
    test_store_single();
    test_order();
    test_full_wrap();
    test_spurious_err();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
